// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: in-order WB writes vs. buffered MDU results.
// Optional same-cycle MDU bypass into an empty buffer is enabled by defining WB_ARB_BYPASS_EN.
module wb_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_addr,
  input  logic [31:0] mdu_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stall_pipe,
  output logic [31:0] pend_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [4:0]       addr_q [DEPTH];
  logic [4:0]       addr_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;

  logic        head_present, head_valid, full, stall;
  logic        wb_ok, wb_grant, head_grant, byp, push, pop;
  logic        we_s;
  logic [4:0]  waddr_s;
  logic [31:0] wdata_s;
  logic [31:0] mask_s;

  // Grant selection, buffer push/pop/squash and starve-counter next state
  always_comb begin
    valid_d  = valid_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    head_present = (count_q != {CW{1'b0}});
    head_valid   = head_present & valid_q[rd_ptr_q];
    full         = (count_q == FULL_CNT);
    stall        = (starve_q == STARVE_MAX) & head_valid;
    wb_ok        = wb_we & (wb_addr != 5'd0);
    wb_grant     = ~stall & wb_ok;
    head_grant   = head_valid & (stall | ~wb_ok);
    // A squashed (invalid) head leaves without touching the register file
    pop          = head_grant | (head_present & ~valid_q[rd_ptr_q]);
`ifdef WB_ARB_BYPASS_EN
    byp          = ~head_present & ~wb_grant & mdu_valid & (mdu_addr != 5'd0);
`else
    byp          = 1'b0;
`endif
    push         = mdu_valid & ~full & (mdu_addr != 5'd0) & ~byp;

    if (head_grant) begin
      we_s    = 1'b1;
      waddr_s = addr_q[rd_ptr_q];
      wdata_s = data_q[rd_ptr_q];
    end else if (wb_grant) begin
      we_s    = 1'b1;
      waddr_s = wb_addr;
      wdata_s = wb_data;
    end else if (byp) begin
      we_s    = 1'b1;
      waddr_s = mdu_addr;
      wdata_s = mdu_data;
    end else begin
      we_s    = 1'b0;
      waddr_s = 5'd0;
      wdata_s = 32'd0;
    end

    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      addr_d[wr_ptr_q]  = mdu_addr;
      data_d[wr_ptr_q]  = mdu_data;
      wr_ptr_d          = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    // Squash runs after push so a same-cycle entry to the same register is also killed
    for (int i = 0; i < DEPTH; i++) begin
      if (wb_grant && (addr_d[i] == wb_addr)) begin
        valid_d[i] = 1'b0;
      end else begin
        valid_d[i] = valid_d[i];
      end
    end

    count_d = count_q + CW'(push) - CW'(pop);

    if (pop || !head_present) begin
      starve_d = {SW{1'b0}};
    end else if (head_valid && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + {{(SW-1){1'b0}}, 1'b1};
    end else begin
      starve_d = starve_q;
    end
  end

  // Pending-destination mask from registered entry state
  always_comb begin
    mask_s = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        mask_s[addr_q[i]] = 1'b1;
      end else begin
        mask_s = mask_s;
      end
    end
  end

  // Output drive, forced quiet while reset is asserted
  always_comb begin
    if (reset_n) begin
      rf_we      = we_s;
      rf_waddr   = waddr_s;
      rf_wdata   = wdata_s;
      stall_pipe = stall;
      pend_mask  = mask_s;
      mdu_ready  = ~full;
    end else begin
      rf_we      = 1'b0;
      rf_waddr   = 5'd0;
      rf_wdata   = 32'd0;
      stall_pipe = 1'b0;
      pend_mask  = 32'd0;
      mdu_ready  = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q  <= {DEPTH{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      starve_q <= {SW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= 5'd0;
        data_q[i] <= 32'd0;
      end
    end else begin
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: expected register-file writes are queued by
// the stimulus and popped by a negedge monitor; per-cycle status outputs are checked directly.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_pipe;
  logic [31:0] pend_mask;

  int n_total = 0;
  int n_pass  = 0;
  logic [36:0] exp_q [$];

  wb_port_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
    .mdu_addr(mdu_addr), .mdu_data(mdu_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_pipe(stall_pipe), .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    wb_we = we; wb_addr = wa; wb_data = wd;
    mdu_valid = mv; mdu_addr = ma; mdu_data = md;
  endtask

  // Write monitor: every rf write must match the head of the expected queue
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got r%0d=0x%08h, expected no write at %0t",
                 rf_waddr, rf_wdata, $time);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} === e) n_pass++;
        else $display("FAIL rf_write: got r%0d=0x%08h, expected r%0d=0x%08h at %0t",
                      rf_waddr, rf_wdata, e[36:32], e[31:0], $time);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step(); step();
    #2;
    chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset_stall", {31'd0, stall_pipe}, 32'd0);
    chk("reset_pend", pend_mask, 32'd0);
    chk("reset_ready", {31'd0, mdu_ready}, 32'd0);
    step();
    reset_n = 1'b1;

    // 1: single MDU result into an idle arbiter
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
    expect_wr(5'd5, 32'h1234);
    #2 chk("t1_ready", {31'd0, mdu_ready}, 32'd1);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #2;
`ifdef WB_ARB_BYPASS_EN
    chk("t1_pend_c1", pend_mask, 32'd0);
`else
    chk("t1_pend_c1", pend_mask, 32'h0000_0020);
`endif
    step();
    #2 chk("t1_pend_c2", pend_mask, 32'd0);

    // 2: WB writes every cycle; r9 starves until the forced stall at cycle 9
    for (int c = 0; c < 12; c++) begin
      step();
      drive(1'b1, 5'd1, 32'h100 + c, (c == 0), 5'd9, 32'h99);
      if (c == 9) expect_wr(5'd9, 32'h99);
      else expect_wr(5'd1, 32'h100 + c);
      #2 chk($sformatf("t2_stall_c%0d", c), {31'd0, stall_pipe}, {31'd0, (c == 9)});
    end

    // 3: WB write to r7 squashes a buffered r7
    step();
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd7, 32'hAAAA);
    expect_wr(5'd2, 32'h22);
    step();
    drive(1'b1, 5'd7, 32'hBBBB, 1'b0, 5'd0, 32'd0);
    expect_wr(5'd7, 32'hBBBB);
    #2 chk("t3_pend_before", pend_mask, 32'h0000_0080);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #2 chk("t3_pend_after", pend_mask, 32'd0);
    chk("t3_no_write", {31'd0, rf_we}, 32'd0);
    step();

    // 4: fill the buffer behind WB traffic, try one push while full, then drain in order
    for (int c = 0; c < 5; c++) begin
      step();
      drive(1'b1, 5'd3, 32'h300 + c, 1'b1, 5'(10 + c), 32'hA0 + c);
      expect_wr(5'd3, 32'h300 + c);
      if (c == 3) begin
        #2 chk("t4_ready_last", {31'd0, mdu_ready}, 32'd1);
      end
      if (c == 4) begin
        #2 chk("t4_ready_full", {31'd0, mdu_ready}, 32'd0);
        chk("t4_pend_full", pend_mask, 32'h0000_3C00);
      end
    end
    for (int c = 0; c < 4; c++) expect_wr(5'(10 + c), 32'hA0 + c);
    for (int c = 0; c < 5; c++) begin
      step();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    end
    #2 chk("t4_pend_drained", pend_mask, 32'd0);
    chk("t4_ready_drained", {31'd0, mdu_ready}, 32'd1);

    // 5: writes aimed at $0 from both sources
    step();
    drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
    #2 chk("t5_rf_we", {31'd0, rf_we}, 32'd0);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #2 chk("t5_rf_we_next", {31'd0, rf_we}, 32'd0);
    chk("t5_pend", pend_mask, 32'd0);

    // 6: reset with three results buffered discards them
    for (int c = 0; c < 3; c++) begin
      step();
      drive(1'b1, 5'd4, 32'h400 + c, 1'b1, 5'(20 + c), 32'hC0 + c);
      expect_wr(5'd4, 32'h400 + c);
    end
    #2 chk("t6_pend_pre", pend_mask, 32'h0030_0000);
    step();
    reset_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #2 chk("t6_pend_rst", pend_mask, 32'd0);
    chk("t6_ready_rst", {31'd0, mdu_ready}, 32'd0);
    step();
    reset_n = 1'b1;
    #2 chk("t6_pend_post", pend_mask, 32'd0);
    chk("t6_ready_post", {31'd0, mdu_ready}, 32'd1);
    chk("t6_rf_we_post", {31'd0, rf_we}, 32'd0);
    step();
    #2 chk("t6_rf_we_post2", {31'd0, rf_we}, 32'd0);

    step(); step();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
